// File: rtl/mca_sequencer.sv
// Sequencer for the multi-clock-adder FIR summation tree: starts the tree, gates it for its
// latency, drives the per-group thermometer enable mask and hands the result downstream.
module mca_sequencer #(
  parameter int K_MAX             = 512,
  parameter int MCA_NUM_ADDITIONS = 16,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int TREE_LATENCY      = 34,
  localparam int G                = K_MAX / MCA_NUM_ADDITIONS,
  localparam int KW               = $clog2(G + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [KW-1:0]                       cfg_k_groups,
  input  logic                                req_valid,
  output logic                                req_ready,
  output logic                                mca_start,
  output logic                                mca_enable_n,
  output logic [G-1:0]                        mca_k_mask,
  input  logic signed [WIDTH_COEFFICIENT-1:0] mca_sample,
  output logic signed [WIDTH_COEFFICIENT-1:0] out_sample,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  localparam int CW = $clog2(TREE_LATENCY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [CW-1:0] count_r;
  logic [KW-1:0] k_clamp_s;
  logic          k_zero_r;

  // Group i is enabled when i < k; k == G therefore yields all ones.
  function automatic logic [G-1:0] thermometer(input logic [KW-1:0] k);
    logic [G-1:0] m;
    m = '0;
    for (int i = 0; i < G; i++) begin
      if (i < int'(k)) m[i] = 1'b1;
      else             m[i] = 1'b0;
    end
    return m;
  endfunction

  assign req_ready = (state_r == S_IDLE);

  // Clamp the requested group count to the number of physical groups.
  always_comb begin
    if (cfg_k_groups > KW'(G)) k_clamp_s = KW'(G);
    else                       k_clamp_s = cfg_k_groups;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) state_nxt_s = S_START;
        else           state_nxt_s = S_IDLE;
      end
      S_START: state_nxt_s = S_RUN;
      S_RUN: begin
        if (count_r == '0) state_nxt_s = S_DONE;
        else               state_nxt_s = S_RUN;
      end
      S_DONE: begin
        if (out_ready) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, counter and registered outputs; tree controls are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      count_r      <= '0;
      k_zero_r     <= 1'b0;
      mca_start    <= 1'b0;
      mca_enable_n <= 1'b0;
      mca_k_mask   <= '0;
      out_sample   <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mca_start    <= (state_nxt_s == S_START);
      mca_enable_n <= (state_nxt_s == S_START) || (state_nxt_s == S_RUN);
      busy         <= (state_nxt_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          // The mask is only ever loaded here, so it cannot move while the tree is summing.
          if (req_valid) begin
            mca_k_mask <= thermometer(k_clamp_s);
            k_zero_r   <= (k_clamp_s == '0);
          end
        end
        S_START: count_r <= CW'(TREE_LATENCY - 1);
        S_RUN: begin
          if (count_r == '0) begin
            out_sample <= k_zero_r ? '0 : mca_sample;
            out_valid  <= 1'b1;
          end else begin
            count_r <= count_r - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mca_sequencer.sv
// Randomised bench for mca_sequencer: a cycle-level scoreboard predicts every output from
// the acceptance cycle of each request and a deterministic tree-result model.
module tb_mca_sequencer;

  localparam int G  = 32;
  localparam int TL = 34;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [5:0]         cfg_k_groups = 6'd0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               mca_start;
  logic               mca_enable_n;
  logic [G-1:0]       mca_k_mask;
  logic signed [31:0] mca_sample;
  logic signed [31:0] out_sample;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               busy;

  int unsigned cyc = 0;
  logic [31:0] seed = 32'd0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned acc;
    logic [31:0] val;
    logic [31:0] mask;
  } op_t;
  op_t sb[$];

  mca_sequencer dut (
    .clk(clk), .reset(reset), .cfg_k_groups(cfg_k_groups),
    .req_valid(req_valid), .req_ready(req_ready),
    .mca_start(mca_start), .mca_enable_n(mca_enable_n), .mca_k_mask(mca_k_mask),
    .mca_sample(mca_sample), .out_sample(out_sample), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: the tree result during cycle c is a fixed hash of c.
  assign mca_sample = (cyc * 32'h9E3779B1) ^ seed;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endfunction

  // Scoreboard: predictions are pushed when a request is accepted and popped on output transfer.
  initial begin
    bit          armed;
    bit          post_rst;
    bit          live;
    int unsigned rel;
    int unsigned k;
    logic [63:0] m64;
    logic [31:0] t;
    op_t         op;
    armed = 1'b0;
    post_rst = 1'b0;
    forever begin
      @(negedge clk);
      live = (sb.size() > 0);
      rel = live ? (cyc - sb[0].acc) : 0;
      if (armed) begin
        check("req_ready", {31'd0, req_ready}, {31'd0, !live});
        check("busy", {31'd0, busy}, {31'd0, live});
        check("mca_start", {31'd0, mca_start}, {31'd0, live && rel == 1});
        check("mca_enable_n", {31'd0, mca_enable_n}, {31'd0, live && rel >= 1 && rel <= TL + 1});
        check("out_valid", {31'd0, out_valid}, {31'd0, live && rel >= TL + 2});
        if (live && rel >= 1) check("mca_k_mask", mca_k_mask, sb[0].mask);
        if (live && rel >= TL + 2) check("out_sample", out_sample, sb[0].val);
        if (post_rst) begin
          check("reset_mask", mca_k_mask, 32'd0);
          check("reset_out_sample", out_sample, 32'd0);
        end
      end
      post_rst = 1'b0;
      if (reset) begin
        sb.delete();
        armed = 1'b1;
        post_rst = 1'b1;
      end else if (armed) begin
        if (live && rel >= TL + 2 && out_ready) begin
          void'(sb.pop_front());
        end else if (!live && req_valid) begin
          k = (cfg_k_groups > 6'd32) ? 32 : int'(cfg_k_groups);
          m64 = (64'd1 << k) - 64'd1;
          t = cyc + TL + 1;
          op.acc = cyc;
          op.mask = m64[31:0];
          op.val = (k == 0) ? 32'd0 : ((t * 32'h9E3779B1) ^ seed);
          sb.push_back(op);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [5:0] cfg);
    bit got;
    got = 1'b0;
    cfg_k_groups = cfg;
    req_valid = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (sb.size() == 0) done = 1'b1;
      else tick();
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out_valid();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check("out_valid_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    seed = $urandom;
    repeat (4) tick();
    reset = 1'b0;
    tick();

    request(6'd32);
    drain();

    // Config change mid-run must not reach the mask.
    request(6'd5);
    repeat (10) tick();
    cfg_k_groups = 6'd9;
    drain();

    request(6'd0);
    drain();
    request(6'd40);
    drain();

    // Output stall with a competing request held high.
    out_ready = 1'b0;
    request(6'd7);
    cfg_k_groups = 6'd3;
    req_valid = 1'b1;
    wait_out_valid();
    repeat (10) tick();
    out_ready = 1'b1;
    request(6'd3);
    drain();

    // Reset while the run counter is at 12.
    request(6'd12);
    repeat (22) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    request(6'd20);
    drain();

    // Back-to-back with request and out_ready held high.
    out_ready = 1'b1;
    req_valid = 1'b1;
    repeat (4 * (TL + 3) + 2) begin
      tick();
      cfg_k_groups = 6'($urandom_range(0, 40));
    end
    req_valid = 1'b0;
    drain();

    // Random traffic with occasional resets.
    repeat (1500) begin
      tick();
      req_valid = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_k_groups = 6'($urandom_range(0, 63));
      reset = ($urandom_range(0, 299) == 0);
    end
    tick();
    reset = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
